shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier_pkg.sv | 13 +
 rtl/shift_add_multiplier_datapath.sv | 44 ++++
 rtl/shift_add_multiplier.sv | 90 +++++++++
 tb/tb_shift_add_multiplier.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the default operand width.
package shift_add_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_datapath.sv
// Accumulator, adder and shifter for the shift-and-add multiplier.
// Negative-edge registers; {acc, mplier} doubles as the product register.
module shift_add_datapath
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic [WIDTH-1:0]     i_multiplicand,
  input  logic [WIDTH-1:0]     i_multiplier,
  output logic [2*WIDTH-1:0]   o_product
);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;

  assign w_addend  = r_mplier[0] ? r_mcand : '0;
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_addend};
  assign o_product = {r_acc, r_mplier};

  // The carry bit of the sum shifts into the accumulator MSB, the sum LSB
  // into the vacated top of the multiplier register.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
    end else if (i_load) begin
      r_mcand  <= i_multiplicand;
      r_acc    <= '0;
      r_mplier <= i_multiplier;
    end else if (i_step) begin
      r_acc    <= w_sum[WIDTH:1];
      r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one shift-add iteration per falling clock
// edge, fixed latency of WIDTH iterations followed by a one-cycle done strobe.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_count;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  assign w_last = (r_count == CNT_W'(WIDTH - 1));

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_load) begin
      r_count <= '0;
    end else if (w_step) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        // start is deliberately not looked at here: no queued requests
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  shift_add_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk            (clk),
    .reset          (reset),
    .i_load         (w_load),
    .i_step         (w_step),
    .i_multiplicand (multiplicand),
    .i_multiplier   (multiplier),
    .o_product      (product)
  );

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks for shift_add_multiplier (WIDTH=32).
// DUT updates on falling edges; the bench samples and drives on rising edges.
module tb_shift_add_multiplier;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [63:0] product;
  logic        busy;
  logic        done;

  int n_compared;
  int n_mismatched;

  shift_add_multiplier #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Pulse start for one falling edge; returns at the rising edge after the
  // accepting edge, with the operand inputs already scrambled.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    repeat (2) @(posedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    start        = 1'b0;
    multiplicand = ~a;
    multiplier   = ~b;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      @(posedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    n_compared += 3;
    if (busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    if (done !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    if (product !== 64'd0) begin
      n_mismatched++;
      $display("FAIL reset_product: got %h expected 0", product);
    end
    reset = 1'b1;
    $display("reset: busy=%b done=%b product=%h", busy, done, product);
  endtask

  task automatic test_basic;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    logic [63:0] p_done = '0;
    start_op(32'd3, 32'd5);
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = i;
          p_done  = product;
        end
      end
      @(posedge clk);
    end
    n_compared += 6;
    if (busy_cnt != 32) begin
      n_mismatched++;
      $display("FAIL basic_busy_cycles: got %0d expected 32", busy_cnt);
    end
    if (done_cnt != 1) begin
      n_mismatched++;
      $display("FAIL basic_done_count: got %0d expected 1", done_cnt);
    end
    if (done_at != 32) begin
      n_mismatched++;
      $display("FAIL basic_done_latency: got %0d expected 32", done_at);
    end
    if (p_done !== 64'h0000_0000_0000_000F) begin
      n_mismatched++;
      $display("FAIL basic_product: got %h expected 000000000000000f", p_done);
    end
    if (product !== 64'h0000_0000_0000_000F) begin
      n_mismatched++;
      $display("FAIL basic_product_hold: got %h expected 000000000000000f", product);
    end
    if (busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL basic_idle_busy: got %b expected 0", busy);
    end
    $display("basic: 3*5 -> %h done_at=%0d", p_done, done_at);
  endtask

  task automatic test_max;
    int cyc;
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    n_compared += 2;
    if (cyc != 32) begin
      n_mismatched++;
      $display("FAIL max_latency: got %0d expected 32", cyc);
    end
    if (product !== 64'hFFFF_FFFE_0000_0001) begin
      n_mismatched++;
      $display("FAIL max_product: got %h expected fffffffe00000001", product);
    end
    $display("max: ffffffff*ffffffff -> %h", product);
  endtask

  task automatic test_ignored_start;
    int done_cnt = 0;
    logic [63:0] p_done = '0;
    start_op(32'd100, 32'd200);
    repeat (5) @(posedge clk);
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    start        = 1'b1;
    @(posedge clk);
    start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done === 1'b1) begin
        if (done_cnt == 0) p_done = product;
        done_cnt++;
      end
      @(posedge clk);
    end
    n_compared += 3;
    if (done_cnt != 1) begin
      n_mismatched++;
      $display("FAIL ignored_done_count: got %0d expected 1", done_cnt);
    end
    if (p_done !== 64'd20000) begin
      n_mismatched++;
      $display("FAIL ignored_product: got %0d expected 20000", p_done);
    end
    if (product !== 64'd20000) begin
      n_mismatched++;
      $display("FAIL ignored_product_final: got %0d expected 20000", product);
    end
    $display("ignored_start: 100*200 -> %0d dones=%0d", p_done, done_cnt);
  endtask

  task automatic test_reset_mid;
    int cyc;
    int late_done = 0;
    start_op(32'd1234, 32'd5678);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_compared += 3;
    if (busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL midreset_busy: got %b expected 0", busy);
    end
    if (done !== 1'b0) begin
      n_mismatched++;
      $display("FAIL midreset_done: got %b expected 0", done);
    end
    if (product !== 64'd0) begin
      n_mismatched++;
      $display("FAIL midreset_product: got %h expected 0", product);
    end
    @(posedge clk);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) late_done++;
      @(posedge clk);
    end
    n_compared++;
    if (late_done != 0) begin
      n_mismatched++;
      $display("FAIL midreset_late_done: got %0d expected 0", late_done);
    end
    start_op(32'd7, 32'd6);
    wait_done(cyc);
    n_compared += 2;
    if (cyc != 32) begin
      n_mismatched++;
      $display("FAIL midreset_restart_latency: got %0d expected 32", cyc);
    end
    if (product !== 64'd42) begin
      n_mismatched++;
      $display("FAIL midreset_restart_product: got %0d expected 42", product);
    end
    $display("reset_mid: aborted, then 7*6 -> %0d", product);
  endtask

  task automatic test_back_to_back;
    int k = 0;
    int t[2] = '{-1, -1};
    logic [63:0] p[2] = '{64'd0, 64'd0};
    repeat (2) @(posedge clk);
    multiplicand = 32'd2;
    multiplier   = 32'd9;
    start        = 1'b1;
    @(posedge clk);
    multiplicand = 32'd4;
    multiplier   = 32'd4;
    for (int i = 0; i < 100 && k < 2; i++) begin
      if (done === 1'b1) begin
        t[k] = i;
        p[k] = product;
        k++;
      end
      if (k < 2) @(posedge clk);
    end
    start = 1'b0;
    n_compared += 5;
    if (k != 2) begin
      n_mismatched++;
      $display("FAIL b2b_done_count: got %0d expected 2", k);
    end
    if (t[0] != 32) begin
      n_mismatched++;
      $display("FAIL b2b_first_latency: got %0d expected 32", t[0]);
    end
    if (t[1] - t[0] != 34) begin
      n_mismatched++;
      $display("FAIL b2b_spacing: got %0d expected 34", t[1] - t[0]);
    end
    if (p[0] !== 64'd18) begin
      n_mismatched++;
      $display("FAIL b2b_product0: got %0d expected 18", p[0]);
    end
    if (p[1] !== 64'd16) begin
      n_mismatched++;
      $display("FAIL b2b_product1: got %0d expected 16", p[1]);
    end
    $display("back_to_back: %0d then %0d, spacing %0d", p[0], p[1], t[1] - t[0]);
  endtask

  task automatic test_random;
    int cyc;
    int bad = 0;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] expected;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      b = $urandom;
      if (n == 0) a = 32'd0;
      if (n == 1) b = 32'd0;
      expected = {32'd0, a} * {32'd0, b};
      start_op(a, b);
      wait_done(cyc);
      n_compared++;
      if (cyc >= 100 || product !== expected) begin
        n_mismatched++;
        bad++;
        $display("FAIL random_%0d: %h*%h got %h expected %h (cycles %0d)",
                 n, a, b, product, expected, cyc);
      end
    end
    $display("random: 1000 operations, %0d wrong", bad);
  endtask

  initial begin
    clk          = 1'b1;
    reset        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_basic();
    test_max();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
